// File: rtl/arm_regfile_mp_if.sv
// ----------------------------------------------------------------------------
// arm_regfile_mp_if
//
// Purpose: bundles the decode-side read port and writeback-side write ports
// of the multi-port register file into one interface.
//
// Modports:
//   master - pipeline side: drives read enable/addresses, both write ports
//            and the fetch PC update; receives read data and the stored PC.
//   slave  - register file side (arm_regfile_mp).
//
// Signals:
//   rd_en           1       sample read addresses (0 holds rdata)
//   raddr           NR*AW   read addresses, port k at [k*AW +: AW]
//   rdata           NR*DW   registered read data, port k at [k*DW +: DW]
//   we0/waddr0/wdata0       write port 0 (ALU result)
//   we1/waddr1/wdata1       write port 1 (load / base writeback, wins ties)
//   pc_we/pc_in             next PC from fetch
//   pc_out          DW      stored PC, no read offset
// ----------------------------------------------------------------------------
interface arm_regfile_mp_if #(
    parameter int DW   = 32,
    parameter int NREG = 16,
    parameter int NR   = 3
);
    localparam int AW = $clog2(NREG);

    logic             rd_en;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;

    logic             we0;
    logic [AW-1:0]    waddr0;
    logic [DW-1:0]    wdata0;

    logic             we1;
    logic [AW-1:0]    waddr1;
    logic [DW-1:0]    wdata1;

    logic             pc_we;
    logic [DW-1:0]    pc_in;
    logic [DW-1:0]    pc_out;

    modport master (
        output rd_en, raddr,
        output we0, waddr0, wdata0,
        output we1, waddr1, wdata1,
        output pc_we, pc_in,
        input  rdata, pc_out
    );

    modport slave (
        input  rd_en, raddr,
        input  we0, waddr0, wdata0,
        input  we1, waddr1, wdata1,
        input  pc_we, pc_in,
        output rdata, pc_out
    );
endinterface

// File: rtl/arm_regfile_mp.sv
// ----------------------------------------------------------------------------
// arm_regfile_mp
//
// Purpose: parametrised multi-port register file for the pipelined ARM core.
// Sits between decode (read addresses) and writeback (write ports) and owns
// the architectural PC register (index PC_IDX).
//
//   - NR registered read ports with a common hold (rd_en=0 keeps rdata).
//   - Two write ports; port 1 beats port 0 on an address collision.
//   - PC register follows pc_in every cycle pc_we=1 unless a write port
//     targets PC_IDX in the same cycle.
//   - Reading PC_IDX through a read port returns PC + PC_RD_OFS (mod 2^DW);
//     pc_out is the raw stored PC.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high; clears all registers and rdata
//   bus    slave modport of arm_regfile_mp_if (see that file for signals)
//
// Configuration:
//   REGFILE_BYPASS_EN  when defined, reads see this cycle's pending write
//                      (port 1, then port 0, then pc_in, then stored value).
//                      When undefined, reads see only stored values and no
//                      combinational path exists from write ports to rdata.
// ----------------------------------------------------------------------------
module arm_regfile_mp #(
    parameter int DW        = 32,
    parameter int NREG      = 16,
    parameter int NR        = 3,
    parameter int PC_IDX    = 15,
    parameter int PC_RD_OFS = 8
) (
    input  logic               clk,
    input  logic               reset,
    arm_regfile_mp_if.slave    bus
);
    localparam int AW = $clog2(NREG);
    localparam logic [AW-1:0] PC_ADDR = AW'(PC_IDX);

    // Adds the pipeline read offset when the register read is the PC; the
    // sum wraps naturally at DW bits.
    function automatic logic [DW-1:0] pcReadAdjust(input logic [DW-1:0] value,
                                                   input logic          isPc);
        return isPc ? value + DW'(PC_RD_OFS) : value;
    endfunction

    logic [DW-1:0]    regs     [NREG];
    logic [DW-1:0]    regsNext [NREG];
    logic [DW-1:0]    readVal  [NR];
    logic [NR*DW-1:0] rdataQ;

    // Next-state for every register. Later assignments win, which encodes
    // the priority: port 1 over port 0 over the fetch PC update.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regsNext[r] = regs[r];
            if (r == PC_IDX && bus.pc_we) begin
                regsNext[r] = bus.pc_in;
            end
            if (bus.we0 && bus.waddr0 == AW'(r)) begin
                regsNext[r] = bus.wdata0;
            end
            if (bus.we1 && bus.waddr1 == AW'(r)) begin
                regsNext[r] = bus.wdata1;
            end
        end
    end

    // Read-port value selection. With bypass, the already-prioritised
    // next-state is the forwarded value, so the same priority applies.
    always_comb begin
        for (int k = 0; k < NR; k++) begin
`ifdef REGFILE_BYPASS_EN
            readVal[k] = pcReadAdjust(regsNext[bus.raddr[k*AW +: AW]],
                                      bus.raddr[k*AW +: AW] == PC_ADDR);
`else
            readVal[k] = pcReadAdjust(regs[bus.raddr[k*AW +: AW]],
                                      bus.raddr[k*AW +: AW] == PC_ADDR);
`endif
        end
    end

    // Register array and read-data stage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
            rdataQ <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= regsNext[r];
            end
            if (bus.rd_en) begin
                for (int k = 0; k < NR; k++) begin
                    rdataQ[k*DW +: DW] <= readVal[k];
                end
            end
        end
    end

    assign bus.rdata  = rdataQ;
    assign bus.pc_out = regs[PC_IDX];

endmodule

// File: tb/tb_arm_regfile_mp.sv
// ----------------------------------------------------------------------------
// tb_arm_regfile_mp
//
// Self-checking bench for arm_regfile_mp (default parameters: 16x32, three
// read ports, PC at r15, read offset 8). Directed scenarios followed by
// randomized traffic; a behavioural model of the register file is checked
// against rdata and pc_out on every falling edge. Honors REGFILE_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_arm_regfile_mp;
    localparam int DW = 32;
    localparam int NREG = 16;
    localparam int NR = 3;
    localparam int AW = 4;

    logic clk;
    logic reset;

    arm_regfile_mp_if #(.DW(DW), .NREG(NREG), .NR(NR)) bus ();

    arm_regfile_mp #(
        .DW(DW), .NREG(NREG), .NR(NR), .PC_IDX(15), .PC_RD_OFS(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passCnt  = 0;
    int totalCnt = 0;

    // Behavioural model state
    logic [31:0] mReg  [16];
    logic [31:0] expRd [3];
    bit          mValid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rdPort(input int k);
        return bus.rdata[k*DW +: DW];
    endfunction

    // Computes the model's next state from the inputs presented this cycle,
    // then lets the edge happen and commits the model just after it.
    task automatic tick();
        logic [31:0] nxt [16];
        logic [31:0] rd  [3];
        logic [3:0]  a;
        logic [31:0] v;
        bit          nv;
        nv = mValid;
        for (int i = 0; i < 16; i++) nxt[i] = mReg[i];
        for (int k = 0; k < 3; k++) rd[k] = expRd[k];
        if (reset) begin
            for (int i = 0; i < 16; i++) nxt[i] = 32'h0;
            for (int k = 0; k < 3; k++) rd[k] = 32'h0;
            nv = 1;
        end else begin
            if (bus.pc_we) nxt[15] = bus.pc_in;
            if (bus.we0)   nxt[bus.waddr0] = bus.wdata0;
            if (bus.we1)   nxt[bus.waddr1] = bus.wdata1;
            if (bus.rd_en) begin
                for (int k = 0; k < 3; k++) begin
                    a = bus.raddr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
                    v = nxt[a];
`else
                    v = mReg[a];
`endif
                    if (a == 4'd15) v = v + 32'd8;
                    rd[k] = v;
                end
            end
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < 16; i++) mReg[i] = nxt[i];
        for (int k = 0; k < 3; k++) expRd[k] = rd[k];
        mValid = nv;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (mValid) begin
            check("model_rdata0", rdPort(0), expRd[0]);
            check("model_rdata1", rdPort(1), expRd[1]);
            check("model_rdata2", rdPort(2), expRd[2]);
            check("model_pc_out", bus.pc_out, mReg[15]);
        end
    end

    task automatic idle();
        bus.we0 = 0; bus.we1 = 0; bus.pc_we = 0;
    endtask

    task automatic setRaddr(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        bus.raddr = {a2, a1, a0};
    endtask

    initial begin
        reset = 1;
        bus.rd_en = 0; bus.raddr = '0;
        bus.we0 = 0; bus.waddr0 = '0; bus.wdata0 = '0;
        bus.we1 = 0; bus.waddr1 = '0; bus.wdata1 = '0;
        bus.pc_we = 0; bus.pc_in = '0;
        for (int i = 0; i < 16; i++) mReg[i] = 32'h0;
        for (int k = 0; k < 3; k++) expRd[k] = 32'h0;

        // Reset state
        tick(); tick();
        reset = 0;
        check("reset_rdata", bus.rdata[31:0] | bus.rdata[63:32] | bus.rdata[95:64], 32'h0);
        check("reset_pc_out", bus.pc_out, 32'h0);

        // Read {0,5,15}: only the PC port shows the offset
        bus.rd_en = 1; setRaddr(4'd0, 4'd5, 4'd15);
        tick();
        check("rd_r0", rdPort(0), 32'h0);
        check("rd_r5", rdPort(1), 32'h0);
        check("rd_pc_ofs", rdPort(2), 32'h8);

        // Single write, then read one cycle later
        bus.rd_en = 0; bus.we0 = 1; bus.waddr0 = 4'd3; bus.wdata0 = 32'hDEADBEEF;
        tick();
        idle(); bus.rd_en = 1; setRaddr(4'd3, 4'd0, 4'd0);
        tick();
        check("rd_r3", rdPort(0), 32'hDEADBEEF);

        // Collision: port 1 wins
        bus.we0 = 1; bus.waddr0 = 4'd7; bus.wdata0 = 32'h11;
        bus.we1 = 1; bus.waddr1 = 4'd7; bus.wdata1 = 32'h22;
        tick();
        idle(); setRaddr(4'd7, 4'd0, 4'd0);
        tick();
        check("collide_r7", rdPort(0), 32'h22);

        // Two writes to different addresses in one cycle
        bus.we0 = 1; bus.waddr0 = 4'd1; bus.wdata0 = 32'hAA;
        bus.we1 = 1; bus.waddr1 = 4'd2; bus.wdata1 = 32'hBB;
        tick();
        idle(); setRaddr(4'd1, 4'd2, 4'd0);
        tick();
        check("dual_r1", rdPort(0), 32'hAA);
        check("dual_r2", rdPort(1), 32'hBB);

        // Write port to PC overrides pc_we; then plain PC update
        bus.pc_we = 1; bus.pc_in = 32'h40;
        bus.we1 = 1; bus.waddr1 = 4'd15; bus.wdata1 = 32'h200;
        tick();
        check("pc_override", bus.pc_out, 32'h200);
        idle(); bus.pc_we = 1; bus.pc_in = 32'h204;
        tick();
        check("pc_update", bus.pc_out, 32'h204);
        idle();

        // Hold: rdata keeps r3 while address moves to r4
        setRaddr(4'd3, 4'd0, 4'd0);
        bus.we0 = 1; bus.waddr0 = 4'd4; bus.wdata0 = 32'h55;
        tick();
        idle(); bus.rd_en = 0; setRaddr(4'd4, 4'd4, 4'd4);
        tick();
        check("hold_r3", rdPort(0), 32'hDEADBEEF);
        bus.rd_en = 1;
        tick();
        check("release_r4", rdPort(0), 32'h55);

        // Same-cycle write/read of r6
        bus.we0 = 1; bus.waddr0 = 4'd6; bus.wdata0 = 32'h1;
        tick();
        bus.wdata0 = 32'h99; setRaddr(4'd6, 4'd0, 4'd0);
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_r6", rdPort(0), 32'h99);
`else
        check("same_cycle_r6", rdPort(0), 32'h1);
`endif

        // PC read offset wraps modulo 2^32
        bus.we0 = 1; bus.waddr0 = 4'd15; bus.wdata0 = 32'hFFFFFFFC;
        tick();
        idle(); setRaddr(4'd15, 4'd0, 4'd0);
        tick();
        check("pc_wrap", rdPort(0), 32'h00000004);
        check("pc_out_raw", bus.pc_out, 32'hFFFFFFFC);

        // Reset mid-stream discards a concurrent write
        reset = 1; bus.we0 = 1; bus.waddr0 = 4'd9; bus.wdata0 = 32'h123;
        tick();
        reset = 0; idle(); setRaddr(4'd9, 4'd15, 4'd3);
        check("midreset_rdata", rdPort(0), 32'h0);
        tick();
        check("midreset_r9", rdPort(0), 32'h0);
        check("midreset_pc", rdPort(1), 32'h8);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            bus.rd_en  = ($urandom_range(0, 3) != 0);
            bus.raddr  = 12'($urandom);
            bus.we0    = $urandom_range(0, 1) == 1;
            bus.waddr0 = 4'($urandom);
            bus.wdata0 = $urandom;
            bus.we1    = ($urandom_range(0, 2) == 0);
            bus.waddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr0 : 4'($urandom);
            bus.wdata1 = $urandom;
            bus.pc_we  = $urandom_range(0, 1) == 1;
            bus.pc_in  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7))) : $urandom;
            tick();
        end
        reset = 0; idle(); bus.rd_en = 0;
        tick();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/arm_regfile_mp.md
Name: arm_regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined ARM core; replaces the fixed 3-read/1-write, 16x32 file.
- Sits between the decode stage (read addresses) and the writeback stage (write ports). Owns the architectural PC register.
- Reads are registered and have a stall hold. Two write ports with fixed priority. Per-cycle PC update that a writeback to the PC index overrides.

Parameters:
- DW, 32, data width in bits.
- NREG, 16, number of registers (power of 2); AW = log2(NREG).
- NR, 3, number of read ports (1..4).
- PC_IDX, 15, index of the register that holds the PC.
- PC_RD_OFS, 8, constant added to the PC when it is read through a read port.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- rd_en  in  1  1: sample read addresses this cycle; 0: hold rdata.
- raddr  in  NR*AW  read addresses; port k is bits [k*AW +: AW].
- rdata  out  NR*DW  registered read data; port k is bits [k*DW +: DW].
- we0  in  1  write enable, port 0 (ALU result).
- waddr0  in  AW  write address, port 0.
- wdata0  in  DW  write data, port 0.
- we1  in  1  write enable, port 1 (load / base writeback; higher priority).
- waddr1  in  AW  write address, port 1.
- wdata1  in  DW  write data, port 1.
- pc_we  in  1  load pc_in into register PC_IDX.
- pc_in  in  DW  next PC from fetch.
- pc_out  out  DW  current stored PC (combinational from the register).

Behaviour:
- Reset (clk edge with reset=1):
  - All NREG registers are cleared to 0 and every rdata port is cleared to 0.
  - All writes and reads are ignored on that edge.
  - Reset asserted mid-stream discards any write presented on the same edge.
- Writes (edge with reset=0):
  - Register r is loaded from port 1 if we1 && waddr1==r, otherwise from port 0 if we0 && waddr0==r.
  - Both ports writing the same address in the same cycle: port 1 wins; the port 0 data is dropped.
  - Both ports writing different addresses: both writes complete in that cycle.
- PC register update:
  - A write port targeting PC_IDX, using the port priority above, overrides pc_we.
  - Otherwise, if pc_we=1, PC <= pc_in.
  - Otherwise the PC holds its value.
- Reads:
  - On an edge with rd_en=1, rdata[k] <= value(raddr[k]). Latency is 1 cycle from address to data.
  - rd_en=0 holds all rdata ports unchanged, regardless of address or write activity.
  - value(a) = reg[a] for a != PC_IDX.
  - value(PC_IDX) = reg[PC_IDX] + PC_RD_OFS. The sum is truncated to DW bits (wraps modulo 2^DW).
- Without bypass (see Optional Feature), a read in the same cycle as a write to the same address returns the pre-write value.
- pc_out = reg[PC_IDX] with no offset.
- All read ports are independent; any number of ports may read the same address.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - value(a) sees this cycle's pending write using the write-priority rule: port 1 data, then port 0 data, then for PC_IDX the pc_in value when pc_we=1, then the stored value.
  - PC_RD_OFS is still added for PC_IDX, so a write of 0x100 to the PC read the same cycle gives 0x108.
  - This removes the writeback-to-decode forwarding path from the hazard unit.
- Undefined: reads return only the stored values; no combinational path runs from the write ports to rdata.

Test Plan:
- Reset, then rd_en=1 with raddr={0,5,15} -> rdata all 0 except port 2 = 0x00000008; pc_out = 0.
- we0: r3=0xDEADBEEF, next cycle read r3 on port 0 -> rdata0 = 0xDEADBEEF exactly one cycle after the address is sampled.
- we0 and we1 both target r7 (0x11 / 0x22) -> r7 = 0x22. Also we0 r1=0xAA and we1 r2=0xBB in one cycle -> both stored.
- pc_we=1, pc_in=0x40 plus we1 to r15 = 0x200 in the same cycle -> pc_out = 0x200. Next cycle, pc_we=1, pc_in=0x204 with no write -> pc_out = 0x204.
- Write r4=0x55, then rd_en=0 while raddr is changed to r4 -> rdata holds the previous value; rd_en=1 -> rdata = 0x55.
- Same-cycle we0 r6=0x99 and read r6 (r6 previously 0x1) -> rdata = 0x99 with REGFILE_BYPASS_EN defined, 0x1 without. reg[15]=0xFFFFFFFC read -> 0x00000004 (wrap).
